// File: rtl/level_disp_pkg.sv
// Shared types and constants for the level digit display.
// FSM states, 7-segment codes (active-low {g..a}), HUNDRED.
package level_disp_pkg;

  typedef enum logic {
    IDLE,
    DIV
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

  localparam logic signed [9:0] HUNDRED = 10'sd100;
  localparam logic signed [9:0] TEN     = 10'sd10;

  // h*100 built from shifts: 64h + 32h + 4h
  function automatic logic [9:0] times_hundred(
    input logic [1:0] h
  );
    logic [9:0] hw;
    hw = {8'd0, h};
    return (hw << 6) + (hw << 5) + (hw << 2);
  endfunction

endpackage

// File: rtl/level_digit_display_seg7_decode.sv
// BCD to active-low 7-segment decoder, purely combinational.
// Ports: bcd (4b in), seg (7b out {g,f,e,d,c,b,a}); 10-15 blank.
module seg7_decode
  import level_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/level_digit_display.sv
// 8-bit level to 3 BCD digits via subtract-by-10, muxed to a 3-digit
// common-anode 7-seg. Ports: clk, rst_n (sync, active-low), in_value,
// in_hundreds, in_valid/in_ready, done, digit_err, bcd_out, an, seg.
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module level_digit_display
  import level_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_value,
  input  logic [1:0]  in_hundreds,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        done,
  output logic        digit_err,
  output logic [11:0] bcd_out,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t             state_q, state_d;
  logic signed [9:0]  rem_q, rem_d, rem_in;
  logic [3:0]         tens_q, tens_d;
  logic [1:0]         hund_q, hund_d;
  logic [11:0]        bcd_d;
  logic               err_q, err_d;
  logic               done_d, derr_d;

  // Wide enough that h=3 against small values stays negative
  assign rem_in = signed'({2'b00, in_value})
                - signed'(times_hundred(in_hundreds));

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    bcd_d   = bcd_out;
    err_d   = err_q;
    done_d  = 1'b0;
    derr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (rem_in < 0 || rem_in >= HUNDRED) begin
            derr_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            hund_d  = in_hundreds;
            tens_d  = 4'd0;
            rem_d   = rem_in;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if (rem_q >= TEN) begin
          rem_d  = rem_q - TEN;
          tens_d = tens_q + 4'd1;
        end else begin
          bcd_d   = {2'b00, hund_q, tens_q, rem_q[3:0]};
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      tens_q    <= '0;
      hund_q    <= '0;
      bcd_out   <= '0;
      err_q     <= 1'b0;
      done      <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      tens_q    <= tens_d;
      hund_q    <= hund_d;
      bcd_out   <= bcd_d;
      err_q     <= err_d;
      done      <= done_d;
      digit_err <= derr_d;
    end
  end

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q, idx_nx;
  logic          wrap;
  logic [3:0]    sel_bcd;
  logic [6:0]    dec_seg, seg_nx;
  logic [2:0]    an_nx;
  logic          blank;

  assign wrap = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    idx_nx = 2'd2;
    unique case (1'b1)
      (idx_q == 2'd2): idx_nx = 2'd1;
      (idx_q == 2'd1): idx_nx = 2'd0;
      default:         idx_nx = 2'd2;
    endcase
  end

  // Decode the digit that becomes visible at the wrap edge
  always_comb begin
    sel_bcd = bcd_out[3:0];
    unique case (idx_nx)
      2'd2:    sel_bcd = bcd_out[11:8];
      2'd1:    sel_bcd = bcd_out[7:4];
      default: sel_bcd = bcd_out[3:0];
    endcase
  end

  seg7_decode u_dec (
    .bcd (sel_bcd),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic h_zero, t_zero;
  assign h_zero = (bcd_out[11:8] == 4'd0);
  assign t_zero = (bcd_out[7:4] == 4'd0);
  assign blank  = (idx_nx == 2'd2 && h_zero)
               || (idx_nx == 2'd1 && h_zero && t_zero);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_nx = dec_seg;
    if (err_q)
      seg_nx = SEG_DASH;
    else if (blank)
      seg_nx = SEG_BLANK;
  end

  assign an_nx = ~(3'b001 << idx_nx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd2;
      an    <= 3'b011;
      seg   <= SEG_DIGIT[0];
    end else if (wrap) begin
      cnt_q <= '0;
      idx_q <= idx_nx;
      an    <= an_nx;
      seg   <= seg_nx;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_level_digit_display.sv
// Self-checking bench for level_digit_display (SCAN_DIV=4).
// Directed plan plus randomized values against a digit/scan model.
module tb_level_digit_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_value = '0;
  logic [1:0]  in_hundreds = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        done;
  logic        digit_err;
  logic [11:0] bcd_out;
  logic [2:0]  an;
  logic [6:0]  seg;

  level_digit_display #(.SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_value    (in_value),
    .in_hundreds (in_hundreds),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .done        (done),
    .digit_err   (digit_err),
    .bcd_out     (bcd_out),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  // edges since reset release: slot = cyc / SD
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int ncmp = 0;
  int nfail = 0;
  int m_val = 0;
  bit m_err = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] m_bcd();
    return 12'((m_val / 100) * 256
             + ((m_val / 10) % 10) * 16
             + (m_val % 10));
  endfunction

  function automatic logic [6:0] exp_seg(input int idx);
    int h, t, d;
    h = m_val / 100;
    t = (m_val / 10) % 10;
    d = (idx == 2) ? h : (idx == 1) ? t : m_val % 10;
    if (m_err) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2 && h == 0) return 7'b1111111;
    if (idx == 1 && h == 0 && t == 0) return 7'b1111111;
`endif
    return seg_code(d);
  endfunction

  task automatic check_scan();
    int idx;
    logic [2:0] a;
    repeat (3 * SD + 1) step();
    while (cyc % SD != 0) step();
    for (int k = 0; k < 3; k++) begin
      idx = 2 - ((cyc / SD) % 3);
      a = ~(3'b001 << idx);
      chk("scan_an", 32'(an), 32'(a));
      chk("scan_seg", 32'(seg), 32'(exp_seg(idx)));
      repeat (SD) step();
    end
  endtask

  task automatic send(input int v, input int h);
    int rem, lat, lows;
    logic [11:0] prev;
    rem = v - h * 100;
    prev = m_bcd();
    chk("ready_idle", 32'(in_ready), 32'd1);
    in_value = 8'(v);
    in_hundreds = 2'(h);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (rem >= 0 && rem < 100) begin
      lat = 0;
      lows = 0;
      while (!done && lat < 20) begin
        if (!in_ready) lows++;
        step();
        lat++;
      end
      m_val = v;
      m_err = 1'b0;
      chk("done_seen", 32'(done), 32'd1);
      chk("latency", 32'(lat), 32'(rem / 10 + 1));
      chk("ready_low", 32'(lows), 32'(rem / 10 + 1));
      chk("ready_done", 32'(in_ready), 32'd1);
      chk("bcd", 32'(bcd_out), 32'(m_bcd()));
      step();
      chk("done_pulse", 32'(done), 32'd0);
    end else begin
      m_err = 1'b1;
      chk("err_pulse", 32'(digit_err), 32'd1);
      chk("err_nodone", 32'(done), 32'd0);
      chk("err_bcd", 32'(bcd_out), 32'(prev));
      chk("err_ready", 32'(in_ready), 32'd1);
      step();
      chk("err_once", 32'(digit_err), 32'd0);
    end
  endtask

  initial begin
    int n, v, h;
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(digit_err), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_an", 32'(an), 32'b011);
    chk("rst_seg", 32'(seg), 32'b1000000);
    rst_n = 1'b1;

    send(237, 2);
    check_scan();
    send(99, 0);
    check_scan();
    send(5, 0);
    check_scan();
    send(150, 2);
    check_scan();
    send(255, 2);
    check_scan();

    in_value = 8'd199;
    in_hundreds = 2'd1;
    in_valid = 1'b1;
    step();
    in_value = 8'd42;
    in_hundreds = 2'd0;
    repeat (3) step();
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    m_val = 199;
    m_err = 1'b0;
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_bcd", 32'(bcd_out), 32'h199);
    n = 0;
    repeat (15) begin
      step();
      if (done) n++;
    end
    chk("ign_extra", 32'(n), 32'd0);
    chk("ign_hold", 32'(bcd_out), 32'h199);

    in_value = 8'd180;
    in_hundreds = 2'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    repeat (2) begin
      step();
      if (done) n++;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_val = 0;
    m_err = 1'b0;
    chk("mid_bcd", 32'(bcd_out), 32'd0);
    chk("mid_an", 32'(an), 32'b011);
    chk("mid_seg", 32'(seg), 32'b1000000);
    chk("mid_ready", 32'(in_ready), 32'd1);
    repeat (20) begin
      if (done) n++;
      step();
    end
    chk("mid_nodone", 32'(n), 32'd0);
    check_scan();

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 255));
      h = v / 100;
      if ($urandom_range(0, 4) == 0)
        h = (h + 1 + int'($urandom_range(0, 2))) % 4;
      send(v, h);
      if (i % 10 == 9) check_scan();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
